// File: rtl/uart_word_packer.sv
// Packs UART receiver bytes little-endian into 32-bit words and queues them in a
// first-word-fall-through FIFO, with sticky overflow / framing-error flags and a partial-word timeout.
module uart_word_packer #(
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_ready,
  input  logic [7:0]               rdata,
  input  logic                     ferr,
  output logic                     word_valid,
  output logic [31:0]              word_data,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, BYTE3} cnt_t;

  cnt_t            cnt_q, cnt_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d, ferr_q, ferr_d;

  logic [3:0][7:0] asm_q;
  logic [31:0]     mem_q [DEPTH];

  logic            byte_ok, push, pop, full, wr_en;
  logic [31:0]     word_new;

  function automatic logic sticky(input logic q, input logic set, input logic clr);
    return set | (q & ~clr);
  endfunction

  assign byte_ok    = rx_ready & ~ferr;
  assign push       = byte_ok & (cnt_q == BYTE3);
  assign full       = (level_q == LW'(DEPTH));
  assign word_valid = (level_q != '0);
  assign pop        = word_valid & word_ready;
  // A full FIFO still takes the new word when the head leaves in the same cycle.
  assign wr_en      = push & (~full | pop);
  assign word_new   = {rdata, asm_q[2], asm_q[1], asm_q[0]};

  always_comb begin
    cnt_d   = cnt_q;
    idle_d  = '0;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;

    if (rx_ready) begin
      if (ferr) cnt_d = BYTE0;
      else      cnt_d = cnt_t'(cnt_q + 2'd1);
    end else if (cnt_q != BYTE0) begin
      if (idle_q == TW'(TIMEOUT_CLKS - 1)) cnt_d = BYTE0;
      else                                 idle_d = idle_q + 1'b1;
    end

    if (wr_en) wr_d = wr_q + 1'b1;
    if (pop)   rd_d = rd_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    ovf_d  = sticky(ovf_q, push & ~wr_en, clear_flags);
    ferr_d = sticky(ferr_q, rx_ready & ferr, clear_flags);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= BYTE0;
      idle_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  // Storage needs no reset: the head is masked while empty and every byte lane is rewritten per word.
  always_ff @(posedge clock) begin
    if (byte_ok) asm_q[cnt_q] <= rdata;
    if (wr_en)   mem_q[wr_q]  <= word_new;
  end

  assign word_data = word_valid ? mem_q[rd_q] : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule
